cache_controller: RTL
=====================

# cache_controller

Two-way set-associative, write-through, write-no-allocate data cache between the EXE stage and MEM_Stage. It accepts the EXE stage's load/store requests and answers read hits in the same cycle. On a read miss or any store, it forwards the request downstream to MEM_Stage and holds `ready` low until MEM_Stage reports `mem_ready`. `ready` drives the pipeline freeze.

## Interface
Parameters:
- `SETS`, 64: number of sets, power of two.
- `INDEX_W`, 6: log2(SETS).
- `TAG_W`, 10: tag width; INDEX_W + TAG_W = 16 word-address bits cached.

Ports:
- `clk`  in  1  single clock; the design has one clock.
- `rst`  in  1  synchronous, active-high reset.
- `mem_read_in`  in  1  load request from EXE.
- `mem_write_in`  in  1  store request from EXE.
- `address_in`  in  `LEN_ADDRESS`  byte address from EXE.
- `data_in`  in  `LEN_REGISTER`  store data.
- `ready`  out  1  request complete this cycle; low = freeze pipeline.
- `data_out`  out  `LEN_REGISTER`  load result, valid when `ready` && `mem_read_in`.
- `sram_read`  out  1  to MEM_Stage `mem_read_in`.
- `sram_write`  out  1  to MEM_Stage `mem_write_in`.
- `sram_address`  out  `LEN_ADDRESS`  to MEM_Stage `address_in`; equals `address_in` unmodified.
- `sram_wdata`  out  `LEN_REGISTER`  to MEM_Stage `data_in`; equals `data_in`.
- `sram_rdata`  in  `LEN_REGISTER`  from MEM_Stage `data_out`.
- `sram_ready`  in  1  from MEM_Stage `mem_ready`.

## Operation
- Address decomposition:
  - word = (address_in − 1024) >> 2, truncated to 16 bits.
  - index = word[INDEX_W−1:0].
  - tag = word[15:INDEX_W].
- Per set: two ways, each holding {valid, tag[TAG_W], data[32]}, plus one LRU bit. LRU = index of the way to evict next.
- Hit: the way is valid and its tag equals the request tag. Hitting both ways is impossible by construction.
- FSM states: IDLE, READ_MISS, WRITE.
- IDLE, no request:
  - `ready`=1, `data_out`=0, `sram_read`=`sram_write`=0.
- IDLE, read hit:
  - `ready`=1 and `data_out`=hit data, combinationally, the same cycle.
  - LRU ← other way at the clock edge.
  - Stay in IDLE.
- IDLE, read miss:
  - `ready`=0, `sram_read`=1 combinationally in that cycle.
  - Next state READ_MISS.
- IDLE, write (hit or miss):
  - `ready`=0, `sram_write`=1 combinationally.
  - On a hit, the hit way's data ← `data_in` and LRU ← other way at the edge.
  - On a miss, no allocation.
  - Next state WRITE.
- READ_MISS:
  - `sram_read` held at 1.
  - When `sram_ready`=1:
    - `data_out`=`sram_rdata` and `ready`=1 in that cycle.
    - At the edge, the victim way gets {valid=1, tag, `sram_rdata`}. The victim is way 0 if invalid, else way 1 if invalid, else the LRU way.
    - LRU ← the other way; return to IDLE.
- WRITE:
  - `sram_write` held at 1.
  - When `sram_ready`=1: `ready`=1 that cycle; return to IDLE.
- Upstream holds the request and its operands stable while `ready`=0 (freeze). The block does not re-sample them.
- `mem_read_in` and `mem_write_in` both high: treated as a write.
- Store data written into the cache is never dirty; the SRAM always holds the current value.

## Timing
- Reset, synchronous at the rising edge while `rst`=1:
  - State → IDLE.
  - All valid bits and LRU bits → 0. Tag and data contents don't care.
  - Outputs after reset with no request: `ready`=1, `data_out`=0, `sram_read`=0, `sram_write`=0.
- Reset asserted mid-miss or mid-write:
  - Returns to IDLE next edge; no fill occurs.
  - `sram_read`/`sram_write` drop combinationally once the state is IDLE and the request is gone.
- Latency:
  - Read hit: 0 extra cycles (`ready` high in the request cycle).
  - Miss or write: 1 + N cycles, where N = cycles until `sram_ready`.
  - `ready` is high only in the `sram_ready` cycle.
- `sram_ready` arriving in IDLE is ignored.
- A new request is accepted in the cycle after `ready`=1.
- A read of the same address immediately following a store-hit returns the new data (hit).

## Structure
- Shared constants go in `ISA.v`: `CACHE_SETS`, `CACHE_INDEX_W`, `CACHE_TAG_W`, and the FSM state encodings `CACHE_IDLE`, `CACHE_READ_MISS`, `CACHE_WRITE`.
- One sub-module, `cache_way_array`, holds the valid/tag/data/LRU storage. It has:
  - a combinational read port returning both ways' {valid, tag, data} plus LRU for an index;
  - a synchronous write port for a fill, a data update and an LRU update, with synchronous clear on `rst`.
- The top-level `cache_controller` holds the address split, hit compare, victim select and FSM.

## Test plan
- Reset, then idle → `ready`=1, `sram_read`=`sram_write`=0, `data_out`=0.
- Read 1024 (cold): `sram_read`=1 until an `sram_ready` pulse with `sram_rdata`=0xDEADBEEF → `data_out`=0xDEADBEEF, `ready`=1 that cycle. Re-read 1024 → hit, `ready`=1 same cycle, `sram_read`=0.
- Write 0x12345678 to 1024 after it is cached → `sram_write`=1 until `sram_ready`. Next read of 1024 hits and returns 0x12345678.
- Read 1024, then 1024+256, then 1024+512 (same index 0, three tags) → third fill evicts the 1024 line (LRU). Read 1024+256 then hits; read 1024 misses.
- Write to uncached 2048, then read 2048 → write does not allocate; read misses and issues `sram_read`.
- Assert `rst` during READ_MISS before `sram_ready` → next cycle IDLE, all lines invalid. The same read misses again.

Source files
------------

// File: rtl/cache_controller_pkg.sv
// ============================================================================
// Module      : cache_controller_pkg
// Description : Shared widths, cache geometry and FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_controller_pkg;

    localparam int LEN_ADDRESS     = 32;
    localparam int LEN_REGISTER    = 32;
    localparam int CACHE_SETS      = 64;
    localparam int CACHE_INDEX_W   = 6;
    localparam int CACHE_TAG_W     = 10;
    localparam int CACHE_ADDR_BASE = 1024;

    typedef enum logic [1:0] {
        CACHE_IDLE      = 2'd0,
        CACHE_READ_MISS = 2'd1,
        CACHE_WRITE     = 2'd2
    } cache_state_t;

endpackage

`default_nettype wire

// File: rtl/cache_way_array.sv
// ============================================================================
// Module      : cache_way_array
// Description : Two-way valid/tag/data storage plus per-set LRU bit.
//               Combinational read port, synchronous fill/update/LRU writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_way_array #(
    parameter int SETS    = 64,
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 10,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index,
    output logic [1:0]         rd_valid,
    output logic [TAG_W-1:0]   rd_tag0,
    output logic [TAG_W-1:0]   rd_tag1,
    output logic [DATA_W-1:0]  rd_data0,
    output logic [DATA_W-1:0]  rd_data1,
    output logic               rd_lru,
    input  logic               fill_en,
    input  logic               upd_en,
    input  logic               wr_way,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               lru_en,
    input  logic               lru_val
);

    logic [1:0]        r_valid [SETS];
    logic              r_lru   [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS][2];
    logic [DATA_W-1:0] r_data  [SETS][2];

    assign rd_valid = r_valid[rd_index];
    assign rd_lru   = r_lru[rd_index];
    assign rd_tag0  = r_tag[rd_index][0];
    assign rd_tag1  = r_tag[rd_index][1];
    assign rd_data0 = r_data[rd_index][0];
    assign rd_data1 = r_data[rd_index][1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SETS; i++) begin
                r_valid[i] <= 2'b00;
                r_lru[i]   <= 1'b0;
            end
        end else begin
            if (fill_en) r_valid[wr_index][wr_way] <= 1'b1;
            if (lru_en)  r_lru[wr_index]           <= lru_val;
        end
    end

    // Tag/data need no reset; a held-off write during rst keeps a mid-miss fill from landing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (fill_en)          r_tag[wr_index][wr_way]  <= wr_tag;
            if (fill_en || upd_en) r_data[wr_index][wr_way] <= wr_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cache_controller.sv
// ============================================================================
// Module      : cache_controller
// Description : Two-way set-associative, write-through, write-no-allocate
//               data cache between EXE and MEM_Stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_controller
    import cache_controller_pkg::*;
#(
    parameter int SETS    = CACHE_SETS,
    parameter int INDEX_W = CACHE_INDEX_W,
    parameter int TAG_W   = CACHE_TAG_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_read_in,
    input  logic                    mem_write_in,
    input  logic [LEN_ADDRESS-1:0]  address_in,
    input  logic [LEN_REGISTER-1:0] data_in,
    output logic                    ready,
    output logic [LEN_REGISTER-1:0] data_out,
    output logic                    sram_read,
    output logic                    sram_write,
    output logic [LEN_ADDRESS-1:0]  sram_address,
    output logic [LEN_REGISTER-1:0] sram_wdata,
    input  logic [LEN_REGISTER-1:0] sram_rdata,
    input  logic                    sram_ready
);

    localparam int c_WORD_W = INDEX_W + TAG_W;

    cache_state_t r_state;
    cache_state_t w_state_next;

    logic [c_WORD_W-1:0]     w_word;
    logic [INDEX_W-1:0]      w_index;
    logic [TAG_W-1:0]        w_tag;
    logic [1:0]              w_valid;
    logic [TAG_W-1:0]        w_tag0;
    logic [TAG_W-1:0]        w_tag1;
    logic [LEN_REGISTER-1:0] w_data0;
    logic [LEN_REGISTER-1:0] w_data1;
    logic                    w_lru;
    logic                    w_hit0;
    logic                    w_hit1;
    logic                    w_hit;
    logic [LEN_REGISTER-1:0] w_hit_data;
    logic                    w_victim;
    logic                    w_fill_en;
    logic                    w_upd_en;
    logic                    w_wr_way;
    logic [LEN_REGISTER-1:0] w_wr_data;
    logic                    w_lru_en;
    logic                    w_lru_val;

    // Word address relative to the data segment base; upper bits alias by design.
    assign w_word  = c_WORD_W'((address_in - LEN_ADDRESS'(CACHE_ADDR_BASE)) >> 2);
    assign w_index = w_word[INDEX_W-1:0];
    assign w_tag   = w_word[INDEX_W +: TAG_W];

    assign sram_address = address_in;
    assign sram_wdata   = data_in;

    cache_way_array #(
        .SETS    (SETS),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (LEN_REGISTER)
    ) u_way_array (
        .clk      (clk),
        .rst      (rst),
        .rd_index (w_index),
        .rd_valid (w_valid),
        .rd_tag0  (w_tag0),
        .rd_tag1  (w_tag1),
        .rd_data0 (w_data0),
        .rd_data1 (w_data1),
        .rd_lru   (w_lru),
        .fill_en  (w_fill_en),
        .upd_en   (w_upd_en),
        .wr_way   (w_wr_way),
        .wr_index (w_index),
        .wr_tag   (w_tag),
        .wr_data  (w_wr_data),
        .lru_en   (w_lru_en),
        .lru_val  (w_lru_val)
    );

    assign w_hit0     = w_valid[0] && (w_tag0 == w_tag);
    assign w_hit1     = w_valid[1] && (w_tag1 == w_tag);
    assign w_hit      = w_hit0 || w_hit1;
    assign w_hit_data = w_hit1 ? w_data1 : w_data0;
    assign w_victim   = !w_valid[0] ? 1'b0 : (!w_valid[1] ? 1'b1 : w_lru);

    always_ff @(posedge clk) begin
        if (rst) r_state <= CACHE_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        data_out     = '0;
        sram_read    = 1'b0;
        sram_write   = 1'b0;
        w_fill_en    = 1'b0;
        w_upd_en     = 1'b0;
        w_wr_way     = 1'b0;
        w_wr_data    = data_in;
        w_lru_en     = 1'b0;
        w_lru_val    = 1'b0;
        case (r_state)
            CACHE_IDLE: begin
                if (mem_write_in) begin
                    sram_write   = 1'b1;
                    w_state_next = CACHE_WRITE;
                    if (w_hit) begin
                        w_upd_en  = 1'b1;
                        w_wr_way  = w_hit1;
                        w_lru_en  = 1'b1;
                        w_lru_val = ~w_hit1;
                    end
                end else if (mem_read_in) begin
                    if (w_hit) begin
                        ready     = 1'b1;
                        data_out  = w_hit_data;
                        w_lru_en  = 1'b1;
                        w_lru_val = ~w_hit1;
                    end else begin
                        sram_read    = 1'b1;
                        w_state_next = CACHE_READ_MISS;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            CACHE_READ_MISS: begin
                sram_read = 1'b1;
                if (sram_ready) begin
                    ready        = 1'b1;
                    data_out     = sram_rdata;
                    w_fill_en    = 1'b1;
                    w_wr_way     = w_victim;
                    w_wr_data    = sram_rdata;
                    w_lru_en     = 1'b1;
                    w_lru_val    = ~w_victim;
                    w_state_next = CACHE_IDLE;
                end
            end
            CACHE_WRITE: begin
                sram_write = 1'b1;
                if (sram_ready) begin
                    ready        = 1'b1;
                    w_state_next = CACHE_IDLE;
                end
            end
            default: w_state_next = CACHE_IDLE;
        endcase
    end

endmodule

`default_nettype wire
